i2s_rx_deser: RTL and testbench

- Front-end receiver that turns an I2S serial stream (bclk, ws, sdata from the ADC/codec) into parallel signed 24-bit left/right samples.
- Produces the au_data samples consumed by the audio filter, with per-channel and per-frame valid strobes.
- All serial inputs are asynchronous to sys_clk. They are synchronized and edge-detected internally; no logic is clocked on bclk.

---
 rtl/i2s_rx_deser.sv | 179 +++++++++++++++++
 tb/tb_i2s_rx_deser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deser.sv
// I2S receiver: oversamples bclk/ws/sdata on sys_clk and deserialises signed left/right words.
// Define I2S_RX_LJ_EN for left-justified framing, where the MSB arrives on the ws-edge bit.
module i2s_rx_deser #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     bclk,
  input  logic                     ws,
  input  logic                     sdata,
  output logic signed [DATA_W-1:0] au_left,
  output logic signed [DATA_W-1:0] au_right,
  output logic                     left_vld,
  output logic                     right_vld,
  output logic                     frame_vld,
  output logic                     err_short,
  output logic                     locked
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SH_W  = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, sdata_sync;
  logic                   bclk_d, ws_prev;
  logic                   bclk_s, ws_s, sdata_s;
  logic                   bit_evt, ws_edge;
  logic [SH_W-1:0]        shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      word_nxt;
  logic                   channel, left_ok;
  logic                   load_msb, shift_en, word_done, short_err, toggle_ch, set_left;

  assign bclk_s   = bclk_sync[SYNC_STAGES-1];
  assign ws_s     = ws_sync[SYNC_STAGES-1];
  assign sdata_s  = sdata_sync[SYNC_STAGES-1];
  assign bit_evt  = bclk_s & ~bclk_d;
  assign ws_edge  = bit_evt & (ws_s ^ ws_prev);
  assign word_nxt = {shreg, sdata_s};

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      bclk_sync  <= '0;
      ws_sync    <= '0;
      sdata_sync <= '0;
      bclk_d     <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      ws_sync    <= {ws_sync[SYNC_STAGES-2:0], ws};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      bclk_d     <= bclk_s;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_msb  = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    short_err = 1'b0;
    toggle_ch = 1'b0;
    set_left  = 1'b0;
    if (bit_evt) begin
      case (state)
        IDLE: begin
          if (ws_edge && !ws_s) begin
            set_left = 1'b1;
`ifdef I2S_RX_LJ_EN
            load_msb  = 1'b1;
            state_nxt = SHIFT;
`else
            state_nxt = DELAY;
`endif
          end
        end
        DELAY: begin
          // A ws edge here means the slot was under two bits long.
          if (ws_edge) begin
            short_err = 1'b1;
            toggle_ch = 1'b1;
          end else begin
            load_msb  = 1'b1;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (ws_edge) begin
            short_err = 1'b1;
            toggle_ch = 1'b1;
`ifdef I2S_RX_LJ_EN
            load_msb  = 1'b1;
            state_nxt = SHIFT;
`else
            state_nxt = DELAY;
`endif
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              word_done = 1'b1;
              state_nxt = PAD;
            end
          end
        end
        PAD: begin
          if (ws_edge) begin
            toggle_ch = 1'b1;
`ifdef I2S_RX_LJ_EN
            load_msb  = 1'b1;
            state_nxt = SHIFT;
`else
            state_nxt = DELAY;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      ws_prev   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      channel   <= 1'b0;
      left_ok   <= 1'b0;
      au_left   <= '0;
      au_right  <= '0;
      left_vld  <= 1'b0;
      right_vld <= 1'b0;
      frame_vld <= 1'b0;
      err_short <= 1'b0;
      locked    <= 1'b0;
    end else begin
      left_vld  <= 1'b0;
      right_vld <= 1'b0;
      frame_vld <= 1'b0;
      err_short <= 1'b0;
      if (bit_evt) ws_prev <= ws_s;
      if (load_msb) begin
        shreg   <= SH_W'(sdata_s);
        bit_cnt <= CNT_W'(1);
      end else if (shift_en) begin
        shreg   <= word_nxt[SH_W-1:0];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (set_left)       channel <= 1'b0;
      else if (toggle_ch) channel <= ~channel;
      if (word_done) begin
        if (!channel) begin
          au_left  <= word_nxt;
          left_vld <= 1'b1;
          left_ok  <= 1'b1;
          locked   <= 1'b1;
        end else begin
          au_right  <= word_nxt;
          right_vld <= 1'b1;
          frame_vld <= left_ok;
          left_ok   <= 1'b0;
        end
      end
      if (short_err) begin
        err_short <= 1'b1;
        locked    <= 1'b0;
        left_ok   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Scoreboard bench for i2s_rx_deser: slot-level reference model feeds an expectation queue.
module tb_i2s_rx_deser;

  localparam int DATA_W = 24;
`ifdef I2S_RX_LJ_EN
  localparam int D = 0;
`else
  localparam int D = 1;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic bclk = 1'b0;
  logic ws = 1'b1;
  logic sdata = 1'b0;
  logic [DATA_W-1:0] au_left, au_right;
  logic left_vld, right_vld, frame_vld, err_short, locked;

  i2s_rx_deser #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bclk(bclk), .ws(ws), .sdata(sdata),
    .au_left(au_left), .au_right(au_right), .left_vld(left_vld), .right_vld(right_vld),
    .frame_vld(frame_vld), .err_short(err_short), .locked(locked)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int               kind;   // 0 left word, 1 right word, 2 short-slot error
    logic [DATA_W-1:0] data;
    logic             frame;
    logic             lock;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  half  = 40;

  bit              m_acq, m_prev, m_pend, m_left_ok, m_locked;
  logic [DATA_W-1:0] m_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void push_ev(int k, logic [DATA_W-1:0] d, bit fr, bit lk);
    ev_t e;
    e.kind = k; e.data = d; e.frame = fr; e.lock = lk;
    exp_q.push_back(e);
  endfunction

  // Slot-level protocol model: a slot of len bits on channel ch, first bit = bits[63].
  function automatic void model_slot(bit ch, int len, logic [63:0] bits, bit abandon);
    bit edge_ = (ch != m_prev);
    logic [DATA_W-1:0] w;
    if (edge_ && m_pend) begin
      m_pend = 0; m_left_ok = 0; m_locked = 0;
      push_ev(2, m_left, 1'b0, 1'b0);
    end
    if (abandon) begin
      m_acq = 0; m_pend = 0; m_left_ok = 0; m_locked = 0; m_left = '0; m_prev = ch;
      return;
    end
    if (!m_acq) begin
      if (edge_ && ch == 1'b0) m_acq = 1;
      else begin
        m_prev = ch;
        return;
      end
    end
    m_prev = ch;
    if (len - D >= DATA_W) begin
      w = bits[63-D -: DATA_W];
      if (ch == 1'b0) begin
        m_left = w; m_left_ok = 1; m_locked = 1;
        push_ev(0, w, 1'b0, 1'b1);
      end else begin
        push_ev(1, w, m_left_ok, m_locked);
        m_left_ok = 0;
      end
    end else begin
      m_pend = 1;
    end
  endfunction

  function automatic logic [63:0] native_bits(logic [DATA_W-1:0] w);
    logic [63:0] r = {$urandom(), $urandom()};
`ifdef I2S_RX_LJ_EN
    return {w, r[39:0]};
`else
    return {r[63], w, r[38:0]};
`endif
  endfunction

  task automatic drive_bit(input bit w, input bit b);
    bclk = 1'b0; ws = w; sdata = b;
    #(half);
    bclk = 1'b1;
    #(half);
  endtask

  task automatic send_slot(input bit ch, input int len, input logic [63:0] bits, input int rst_at);
    model_slot(ch, len, bits, rst_at >= 0);
    for (int i = 0; i < len; i++) begin
      bclk = 1'b0; ws = ch; sdata = bits[63-i];
      #(half);
      bclk = 1'b1;
      if (i == rst_at) begin
        @(negedge sys_clk); sys_rst = 1'b0;
        @(negedge sys_clk); sys_rst = 1'b1;
        check("rst au_left", au_left, 0);
        check("rst au_right", au_right, 0);
        check("rst locked", locked, 0);
        check("rst strobes", {err_short, frame_vld, right_vld, left_vld}, 0);
      end
      #(half);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input int len);
    send_slot(1'b0, len, native_bits(l), -1);
    send_slot(1'b1, len, native_bits(r), -1);
  endtask

  always @(negedge sys_clk) begin : monitor
    ev_t e;
    if (left_vld || right_vld || err_short || frame_vld) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected strobe: got err/frame/right/left=%b expected none at %0t",
                 {err_short, frame_vld, right_vld, left_vld}, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobes", {err_short, right_vld, left_vld},
              (e.kind == 0) ? 3'b001 : (e.kind == 1) ? 3'b010 : 3'b100);
        if (e.kind == 1) check("au_right", au_right, e.data);
        else             check(e.kind == 0 ? "au_left" : "au_left hold", au_left, e.data);
        check("frame_vld", frame_vld, e.frame);
        check("locked", locked, e.lock);
      end
    end
  end

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DATA_W-1:0] l, r;
    int len;
    real s;
    m_acq = 0; m_prev = 1; m_pend = 0; m_left_ok = 0; m_locked = 0; m_left = '0;

    repeat (5) @(negedge sys_clk);
    check("reset au_left", au_left, 0);
    check("reset au_right", au_right, 0);
    check("reset locked", locked, 0);
    check("reset strobes", {err_short, frame_vld, right_vld, left_vld}, 0);

    // Stream already mid-right-slot when reset releases.
    for (int i = 0; i < 16; i++) begin
      if (i == 6) sys_rst = 1'b1;
      drive_bit(1'b1, 1'($urandom()));
    end

    send_frame(24'h7F0000, 24'h810000, 32);
    send_frame(24'h7F0000, 24'h810000, 32);

    // Sine sweep at the fastest supported bclk, minimum-length slots.
    half = 20;
    for (int i = 0; i < 128; i++) begin
      s = $sin(6.283185307179586 * i / 128.0) * 8323072.0;
      l = DATA_W'($rtoi(s));
      send_frame(l, DATA_W'($urandom()), DATA_W + D);
    end
    half = 40;

    // Random slot lengths with occasional short slots.
    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 7) == 0) len = $urandom_range(1, DATA_W + D - 1);
        else                           len = $urandom_range(DATA_W + D, 40);
        send_slot(1'(c), len, native_bits(DATA_W'($urandom())), -1);
      end
    end
    send_frame(DATA_W'($urandom()), DATA_W'($urandom()), 32);

    // Short left slot of 16 data bits, then recovery.
    send_slot(1'b0, 16 + D, native_bits(24'h123456), -1);
    send_slot(1'b1, 32, native_bits(24'hABCDEF), -1);
    send_frame(24'h2468AC, 24'hFEDCBA, 32);

    // Reset pulse at bit 12 of a left slot; reacquire on next falling ws.
    send_slot(1'b0, 32, native_bits(24'h555555), 12);
    send_slot(1'b1, 32, native_bits(24'h333333), -1);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 32);

    // Left-justified placement of 24'h000001 with zero padding.
    l = 24'h000001;
    send_slot(1'b0, 32, {l, 40'h0}, -1);
    send_slot(1'b1, 32, native_bits(24'h000777), -1);
    send_frame(24'h400000, 24'hC00000, 32);

    repeat (60) @(negedge sys_clk);
    check("queue drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
